fwd_hazard_sched: RTL and testbench
===================================

// Module: fwd_hazard_sched
// PURPOSE
//  Parametrised operand-forwarding and load-use hazard unit for the pipelined MIPS core. Tracks in-flight
//  register writers in a shift-register scoreboard, one slot per post-issue stage, and returns per-source
//  forward selects for the ID/EX operand muxes. Asserts stall when the youngest matching producer's result
//  is not yet available (multi-cycle latency, e.g. loads). Also counts stall cycles for perf monitoring.
// PARAMETERS
//  NUM_SRC    2  source operands checked per instruction (rs, rt, ...)
//  NUM_STAGES 3  tracked post-issue stages; slot s = instruction issued s cycles ago (1 = EX/MEM)
//  AW         5  register-address width
//  CNT_W      16 stall-counter width
//  derived: SEL_W = LAT_W = $clog2(NUM_STAGES+1)
// PORTS
//  clk          in  1            core clock
//  rst          in  1            asynchronous, active-high reset
//  id_valid     in  1            valid instruction in ID
//  id_src       in  NUM_SRC*AW   source reg addrs, port p at [p*AW +: AW]
//  id_src_used  in  NUM_SRC      port p is actually read by the instruction
//  id_rd        in  AW           destination reg of ID instruction
//  id_reg_write in  1            ID instruction writes id_rd
//  id_lat       in  LAT_W        stage at which result becomes forwardable (1 = ALU, 2 = load)
//  pipe_hold    in  1            global freeze (e.g. memory wait): scoreboard does not move
//  flush        in  1            kill ID instruction and slot-1 entry (branch taken in EX)
//  fwd_sel      out NUM_SRC*SEL_W per port: 0 = regfile, s = forward from slot s
//  stall        out 1            hold PC/IF-ID, inject bubble
//  stall_cnt    out CNT_W        saturating count of stall cycles
// BEHAVIOUR
//  - Slot state: {vld, rd[AW], lat[LAT_W]} x NUM_STAGES, all flops. Reset: all vld=0, stall_cnt=0,
//    hence fwd_sel=0 and stall=0 immediately on rst assertion (async clear).
//  - Match for port p: id_valid & id_src_used[p] & slot vld & slot rd==src & src!=0.
//  - Priority: the lowest-index (youngest) matching slot wins; older matches are ignored.
//  - If winning slot s has s >= lat: fwd_sel[p]=s. Else fwd_sel[p]=0 and the port is hazarded.
//  - stall = OR of hazarded ports, masked by flush. fwd_sel and stall are combinational from state + ID.
//  - Clock edge, pipe_hold=1: slots and stall_cnt unchanged.
//  - Clock edge, pipe_hold=0: slot[s+1]<=slot[s] for s=1..NUM_STAGES-1; slot NUM_STAGES retires
//    (regfile is write-before-read, no forward needed after it).
//    slot[1] <= {id_valid & id_reg_write & ~stall & ~flush & id_rd!=0, id_rd, clamp(id_lat)}; stall -> bubble.
//  - flush: slot-1 entry is not shifted into slot 2 (vld forced 0); ID push suppressed.
//  - id_lat clamp: 0 -> 1; > NUM_STAGES -> NUM_STAGES.
//  - stall_cnt += 1 on each non-hold edge with stall=1; saturates at all-ones, never wraps.
//  - Stall is at most lat-1 consecutive cycles per producer; the bubble advances the producer each cycle.
//  - rd==0 is never tracked; src==0 is never forwarded nor stalled.
//  - Simultaneous stall+flush: flush wins (no stall, no push, slot 1 killed).
// STRUCTURE
//  - Package fwd_pkg: typedef sb_entry_t {vld, rd, lat}; localparams SEL_REGFILE=0, LAT_ALU=1, LAT_LOAD=2.
//  - Sub-module fwd_port_match: combinational priority search over slots for one source port
//    -> {sel, hazard}; generated NUM_SRC times. Top holds scoreboard shift register, stall OR, counter.
// TESTING (NUM_STAGES=3, NUM_SRC=2)
//  1 Issue rd=3 lat=1; next cycle src0=3 used -> fwd_sel[0]=1, stall=0; a cycle later -> fwd_sel[0]=2.
//  2 Issue lw rd=4 lat=2; next cycle src1=4 -> stall=1, stall_cnt 0->1; following cycle fwd_sel[1]=2,
//    stall=0.
//  3 rd=5 in slots 1 and 2 (both lat=1), src0=5 -> fwd_sel[0]=1 (youngest wins).
//  4 Issue rd=0 reg_write=1; next cycle src0=0 -> fwd_sel=0, stall=0; src_used=0 with match -> sel 0.
//  5 rd=6 in slot 1, pipe_hold=1 for 3 cycles -> fwd_sel stays 1, stall_cnt frozen; rd=7 in slot 1
//    + flush -> next cycle src=7 gives sel 0.
//  6 Assert rst asynchronously mid-stall (case 2) -> stall=0, stall_cnt=0, all fwd_sel=0 before next edge.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package fwd_pkg;

    // Default geometry of the scoreboard (MIPS: 32 registers, 3 post-issue stages)
    localparam int DEF_AW         = 5;
    localparam int DEF_NUM_STAGES = 3;
    localparam int DEF_LAT_W      = $clog2(DEF_NUM_STAGES + 1);

    // Forward-select value meaning "read the register file"
    localparam int SEL_REGFILE = 0;
    // Result latencies: ALU results forwardable from slot 1, loads from slot 2
    localparam int LAT_ALU     = 1;
    localparam int LAT_LOAD    = 2;

    // One scoreboard slot at default geometry
    typedef struct packed {
        logic                  vld;
        logic [DEF_AW-1:0]     rd;
        logic [DEF_LAT_W-1:0]  lat;
    } sb_entry_t;

endpackage

// File: rtl/fwd_port_match.sv
// Priority search of the scoreboard for one source operand: the youngest
// matching producer decides between forwarding and a load-use hazard.
module fwd_port_match
    import fwd_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int AW         = 5,
    parameter int LAT_W      = 2,
    parameter int SEL_W      = 2
) (
    input  logic [AW-1:0]               src_i,
    input  logic                        used_i,
    input  logic                        id_valid_i,
    input  logic [NUM_STAGES-1:0]       slot_vld_i,
    input  logic [NUM_STAGES*AW-1:0]    slot_rd_i,
    input  logic [NUM_STAGES*LAT_W-1:0] slot_lat_i,
    output logic [SEL_W-1:0]            sel_o,
    output logic                        hazard_o
);

    logic [SEL_W-1:0] sel_s;
    logic             hazard_s;
    logic             match_s;
    logic             ready_s;

    // Walk from oldest to youngest slot so the youngest match overwrites older ones
    always_comb begin
        sel_s    = SEL_W'(SEL_REGFILE);
        hazard_s = 1'b0;
        match_s  = 1'b0;
        ready_s  = 1'b0;
        for (int s = NUM_STAGES; s >= 1; s--) begin
            match_s = id_valid_i && used_i && (src_i != {AW{1'b0}}) &&
                      slot_vld_i[s-1] && (slot_rd_i[(s-1)*AW +: AW] == src_i);
            ready_s = (LAT_W'(s) >= slot_lat_i[(s-1)*LAT_W +: LAT_W]);
            if (match_s) begin
                sel_s    = ready_s ? SEL_W'(s) : SEL_W'(SEL_REGFILE);
                hazard_s = ~ready_s;
            end else begin
                sel_s    = sel_s;
                hazard_s = hazard_s;
            end
        end
    end

    assign sel_o    = sel_s;
    assign hazard_o = hazard_s;

endmodule

// File: rtl/fwd_hazard_sched.sv
// Operand forwarding and load-use hazard scheduler: shift-register scoreboard
// of in-flight register writers, per-source forward selects, stall and a
// saturating stall-cycle counter.
module fwd_hazard_sched
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int AW         = 5,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(NUM_STAGES + 1),
    localparam int LAT_W     = SEL_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [NUM_SRC*AW-1:0]    id_src,
    input  logic [NUM_SRC-1:0]       id_src_used,
    input  logic [AW-1:0]            id_rd,
    input  logic                     id_reg_write,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic                     pipe_hold,
    input  logic                     flush,
    output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
    output logic                     stall,
    output logic [CNT_W-1:0]         stall_cnt
);

    // Slot s (1-based) lives at index s-1 of each packed vector
    logic [NUM_STAGES-1:0]       vld_q, vld_d;
    logic [NUM_STAGES*AW-1:0]    rd_q, rd_d;
    logic [NUM_STAGES*LAT_W-1:0] lat_q, lat_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    logic [NUM_SRC-1:0]          hazard_s;
    logic                        stall_s;
    logic                        push_s;

    // Latency 0 means "ALU"; anything beyond the tracked depth is capped
    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        if (lat == {LAT_W{1'b0}}) begin
            return LAT_W'(LAT_ALU);
        end else if ({1'b0, lat} > (LAT_W+1)'(NUM_STAGES)) begin
            return LAT_W'(NUM_STAGES);
        end else begin
            return lat;
        end
    endfunction

    genvar p;
    generate
        for (p = 0; p < NUM_SRC; p++) begin : g_port
            fwd_port_match #(
                .NUM_STAGES (NUM_STAGES),
                .AW         (AW),
                .LAT_W      (LAT_W),
                .SEL_W      (SEL_W)
            ) u_match (
                .src_i      (id_src[p*AW +: AW]),
                .used_i     (id_src_used[p]),
                .id_valid_i (id_valid),
                .slot_vld_i (vld_q),
                .slot_rd_i  (rd_q),
                .slot_lat_i (lat_q),
                .sel_o      (fwd_sel[p*SEL_W +: SEL_W]),
                .hazard_o   (hazard_s[p])
            );
        end
    endgenerate

    // A taken branch kills the ID instruction, so it can never stall
    assign stall_s   = (|hazard_s) & ~flush;
    assign push_s    = id_valid & id_reg_write & ~stall_s & ~flush & (id_rd != {AW{1'b0}});
    assign stall     = stall_s;
    assign stall_cnt = cnt_q;

    // Scoreboard advance: age every slot, kill slot 1 on flush, insert ID writer or bubble
    always_comb begin
        vld_d = vld_q;
        rd_d  = rd_q;
        lat_d = lat_q;
        if (!pipe_hold) begin
            for (int s = NUM_STAGES - 1; s >= 1; s--) begin
                if (s == 1) begin
                    vld_d[s] = vld_q[s-1] & ~flush;
                end else begin
                    vld_d[s] = vld_q[s-1];
                end
                rd_d[s*AW +: AW]       = rd_q[(s-1)*AW +: AW];
                lat_d[s*LAT_W +: LAT_W] = lat_q[(s-1)*LAT_W +: LAT_W];
            end
            vld_d[0]          = push_s;
            rd_d[AW-1:0]      = id_rd;
            lat_d[LAT_W-1:0]  = clamp_lat(id_lat);
        end else begin
            vld_d = vld_q;
            rd_d  = rd_q;
            lat_d = lat_q;
        end
    end

    // Stall counter: count stalled, non-frozen edges and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (!pipe_hold && stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= {NUM_STAGES{1'b0}};
            rd_q  <= {(NUM_STAGES*AW){1'b0}};
            lat_q <= {(NUM_STAGES*LAT_W){1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            vld_q <= vld_d;
            rd_q  <= rd_d;
            lat_q <= lat_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_sched.sv
// Self-checking bench for fwd_hazard_sched: directed cases with literal
// expectations plus a randomized run against an in-flight-instruction model.
module tb_fwd_hazard_sched;

    localparam int NS   = 3;
    localparam int CMAX = 255;

    logic        clk, rst;
    logic        id_valid, id_reg_write, pipe_hold, flush;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic [4:0]  id_rd;
    logic [1:0]  id_lat;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic [7:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    fwd_hazard_sched #(.NUM_SRC(2), .NUM_STAGES(NS), .AW(5), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_lat       (id_lat),
        .pipe_hold    (pipe_hold),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // In-flight writers: register, effective latency, cycles since issue.
    typedef struct {
        int rd;
        int lat;
        int age;
    } rec_t;
    rec_t infl[$];
    int   m_cnt = 0;

    function automatic int port_sel(input int src, input bit used, output bit hz);
        int best;
        int bl;
        best = 0;
        bl   = 0;
        hz   = 1'b0;
        if (id_valid && used && src != 0) begin
            foreach (infl[i]) begin
                if (infl[i].rd == src && (best == 0 || infl[i].age < best)) begin
                    best = infl[i].age;
                    bl   = infl[i].lat;
                end
            end
        end
        if (best == 0) return 0;
        if (best >= bl) return best;
        hz = 1'b1;
        return 0;
    endfunction

    function automatic bit model_stall();
        bit h0, h1;
        void'(port_sel(int'(id_src[4:0]), id_src_used[0], h0));
        void'(port_sel(int'(id_src[9:5]), id_src_used[1], h1));
        return (h0 || h1) && !flush;
    endfunction

    task automatic model_step();
        bit   stl;
        bit   push;
        rec_t r;
        if (rst) begin
            infl.delete();
            m_cnt = 0;
        end else if (!pipe_hold) begin
            stl  = model_stall();
            push = id_valid && id_reg_write && !stl && !flush && (id_rd != 5'd0);
            if (flush) begin
                for (int i = infl.size() - 1; i >= 0; i--)
                    if (infl[i].age == 1) infl.delete(i);
            end
            for (int i = infl.size() - 1; i >= 0; i--) begin
                infl[i].age = infl[i].age + 1;
                if (infl[i].age > NS) infl.delete(i);
            end
            if (push) begin
                r.rd  = int'(id_rd);
                r.lat = (id_lat == 2'd0) ? 1 : ((int'(id_lat) > NS) ? NS : int'(id_lat));
                r.age = 1;
                infl.push_back(r);
            end
            if (stl && m_cnt < CMAX) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model advances on every clock edge and on asynchronous reset
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        int  e0, e1;
        bit  h0, h1;
        forever begin
            @(negedge clk);
            if (!rst) begin
                e0 = port_sel(int'(id_src[4:0]), id_src_used[0], h0);
                e1 = port_sel(int'(id_src[9:5]), id_src_used[1], h1);
                check("model_sel0",  int'(fwd_sel[1:0]), e0);
                check("model_sel1",  int'(fwd_sel[3:2]), e1);
                check("model_stall", int'(stall), int'((h0 || h1) && !flush));
                check("model_cnt",   int'(stall_cnt), m_cnt);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(input bit v, input bit rw, input int rd, input int lat,
                          input int s0, input bit u0, input int s1, input bit u1,
                          input bit hold, input bit fl);
        id_valid     = v;
        id_reg_write = rw;
        id_rd        = 5'(rd);
        id_lat       = 2'(lat);
        id_src       = {5'(s1), 5'(s0)};
        id_src_used  = {u1, u0};
        pipe_hold    = hold;
        flush        = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_in(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic issue(input int rd, input int lat);
        set_in(1'b1, 1'b1, rd, lat, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b1;
        set_in(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", int'(stall), 0);
        check("rst_cnt",   int'(stall_cnt), 0);
        check("rst_sel",   int'(fwd_sel), 0);
        rst = 1'b0;
        tick();

        // 1: ALU producer forwarded from slot 1 then slot 2
        issue(3, 1);
        set_in(1'b1, 1'b0, 0, 0, 3, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("c1_sel0_s1", int'(fwd_sel[1:0]), 1);
        check("c1_stall",   int'(stall), 0);
        tick();
        @(negedge clk);
        check("c1_sel0_s2", int'(fwd_sel[1:0]), 2);
        tick();
        idle(3);

        // 2: load-use stall for one cycle, then forward from slot 2
        issue(4, 2);
        set_in(1'b1, 1'b0, 0, 0, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("c2_stall",  int'(stall), 1);
        check("c2_sel1_0", int'(fwd_sel[3:2]), 0);
        check("c2_cnt0",   int'(stall_cnt), 0);
        tick();
        @(negedge clk);
        check("c2_stall_clr", int'(stall), 0);
        check("c2_sel1_2",    int'(fwd_sel[3:2]), 2);
        check("c2_cnt1",      int'(stall_cnt), 1);
        tick();
        idle(3);

        // 3: youngest producer wins
        issue(5, 1);
        issue(5, 1);
        set_in(1'b1, 1'b0, 0, 0, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("c3_youngest", int'(fwd_sel[1:0]), 1);
        tick();
        idle(3);

        // 4: r0 never tracked; unused source never forwarded
        issue(0, 1);
        set_in(1'b1, 1'b0, 0, 0, 0, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("c4_r0_sel",   int'(fwd_sel), 0);
        check("c4_r0_stall", int'(stall), 0);
        tick();
        issue(8, 1);
        set_in(1'b1, 1'b0, 0, 0, 8, 1'b0, 8, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("c4_unused_sel0", int'(fwd_sel[1:0]), 0);
        check("c4_used_sel1",   int'(fwd_sel[3:2]), 1);
        tick();
        idle(3);

        // 5: pipe_hold freezes the scoreboard and counter
        issue(6, 1);
        set_in(1'b1, 1'b0, 0, 0, 6, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("c5_hold_sel", int'(fwd_sel[1:0]), 1);
            check("c5_hold_cnt", int'(stall_cnt), 1);
            tick();
        end
        pipe_hold = 1'b0;
        @(negedge clk);
        check("c5_release_sel", int'(fwd_sel[1:0]), 1);
        tick();
        @(negedge clk);
        check("c5_aged_sel", int'(fwd_sel[1:0]), 2);
        tick();
        idle(3);

        // 5b: flush kills the slot-1 producer
        issue(7, 1);
        set_in(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 0, 0, 7, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("c5_flush_sel", int'(fwd_sel[1:0]), 0);
        tick();
        idle(3);

        // 5c: stall and flush together -> flush wins, no push, no count
        issue(9, 2);
        set_in(1'b1, 1'b1, 10, 1, 9, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("c5_sf_stall", int'(stall), 0);
        tick();
        set_in(1'b1, 1'b0, 0, 0, 10, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("c5_sf_nopush", int'(fwd_sel[1:0]), 0);
        check("c5_sf_killed", int'(fwd_sel[3:2]), 0);
        check("c5_sf_cnt",    int'(stall_cnt), 1);
        tick();
        idle(3);

        // 6: asynchronous reset in the middle of a stall
        issue(4, 2);
        set_in(1'b1, 1'b0, 0, 0, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("c6_stall_pre", int'(stall), 1);
        #2;
        rst = 1'b1;
        #1;
        check("c6_rst_stall", int'(stall), 0);
        check("c6_rst_cnt",   int'(stall_cnt), 0);
        check("c6_rst_sel",   int'(fwd_sel), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            set_in($urandom_range(0, 9) < 8,
                   $urandom_range(0, 9) < 7,
                   int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 9) == 0);
            tick();
        end
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
